// File: rtl/rf_write_arbiter.sv
`default_nettype none
// rf_write_arbiter: shares the register-file write port between WB and an out-of-order
// multi-cycle unit, and tracks in-flight multi-cycle destinations in a busy scoreboard.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_addr,
  input  logic [31:0] mc_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1Addr,
  input  logic [4:0]  rs2Addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic        RegWrite,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [3:0]    STARVE_CNT = 4'(STARVE_LIMIT);

  logic [4:0]    fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_wb_req;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;

  assign w_fifo_empty = (count_q == '0);
  assign w_fifo_full  = (count_q == FULL_CNT);
  assign w_head_addr  = fifo_addr_q[rd_ptr_q];
  assign w_head_data  = fifo_data_q[rd_ptr_q];

  // Stall depends on registered state only, so it has no input-to-output path.
  assign wb_stall = (cnt_q == STARVE_CNT);
  assign mc_ready = !w_fifo_full;

  assign w_wb_req = wb_we && (wb_addr != 5'd0) && !wb_stall;
  assign w_pop    = !w_wb_req && !w_fifo_empty;
  // A zero-destination result is handshaken but never stored.
  assign w_push   = mc_valid && !w_fifo_full && (mc_addr != 5'd0);

  assign rs1_busy = busy_q[rs1Addr];
  assign rs2_busy = busy_q[rs2Addr];
  assign rd_busy  = busy_q[issue_rd];

  always_comb begin
    RegWrite  = 1'b0;
    WriteAddr = 5'd0;
    WriteData = 32'd0;
    if (w_wb_req) begin
      RegWrite  = 1'b1;
      WriteAddr = wb_addr;
      WriteData = wb_data;
    end else if (w_pop) begin
      RegWrite  = 1'b1;
      WriteAddr = w_head_addr;
      WriteData = w_head_data;
    end
  end

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear before set so a same-cycle set of the popped register wins.
  always_comb begin
    busy_d = busy_q;
    if (w_pop) begin
      busy_d[w_head_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = 4'd0;
    if (!w_fifo_empty && w_wb_req) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      cnt_q    <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_addr_q[wr_ptr_q] <= mc_addr;
      fifo_data_q[wr_ptr_q] <= mc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// tb_rf_write_arbiter: directed and random checks of rf_write_arbiter against a queue-based model.
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int SL    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we, mc_valid, issue_valid;
  logic [4:0]  wb_addr, mc_addr, issue_rd, rs1Addr, rs2Addr;
  logic [31:0] wb_data, mc_data;
  logic        wb_stall, mc_ready, rs1_busy, rs2_busy, rd_busy, RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;

  int checks = 0;
  int errors = 0;

  logic [36:0] mq[$];
  logic [31:0] mbusy;
  int          mcnt;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    mc_valid = 1'b0; mc_addr = 5'd0; mc_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy = 32'd0;
    mcnt  = 0;
  endtask

  function automatic logic m_req();
    return wb_we && (wb_addr != 5'd0) && (mcnt != SL);
  endfunction

  task automatic model_check();
    logic        req, pop;
    logic [4:0]  ea;
    logic [31:0] ed;
    req = m_req();
    pop = !req && (mq.size() > 0);
    ea = 5'd0; ed = 32'd0;
    if (req) begin
      ea = wb_addr; ed = wb_data;
    end else if (pop) begin
      ea = mq[0][36:32]; ed = mq[0][31:0];
    end
    chk("wb_stall", wb_stall, mcnt == SL);
    chk("RegWrite", RegWrite, req || pop);
    chk("WriteAddr", WriteAddr, ea);
    chk("WriteData", WriteData, ed);
    chk("mc_ready", mc_ready, mq.size() < DEPTH);
    chk("rs1_busy", rs1_busy, mbusy[rs1Addr]);
    chk("rs2_busy", rs2_busy, mbusy[rs2Addr]);
    chk("rd_busy", rd_busy, mbusy[issue_rd]);
  endtask

  task automatic model_update();
    logic        req, had, ready;
    logic [36:0] head;
    req   = m_req();
    had   = mq.size() > 0;
    ready = mq.size() < DEPTH;
    if (!req && had) begin
      head = mq.pop_front();
      mbusy[head[36:32]] = 1'b0;
    end
    if (issue_valid && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
    mcnt = (had && req) ? mcnt + 1 : 0;
    if (mc_valid && ready && mc_addr != 5'd0) mq.push_back({mc_addr, mc_data});
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    set_idle();
    rs1Addr = 5'd0; rs2Addr = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mc_ready", mc_ready, 1'b1);
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_wb_stall", wb_stall, 1'b0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset with two entries queued and busy[5] set
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hCAFE;
    issue_valid = 1'b1; issue_rd = 5'd5;
    mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'h11;
    step();
    issue_valid = 1'b0; mc_addr = 5'd6; mc_data = 32'h22;
    step();
    wb_we = 1'b0; mc_valid = 1'b0; rs1Addr = 5'd5;
    #1;
    chk("pre_rst_busy5", rs1_busy, 1'b1);
    chk("pre_rst_full", mc_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", mc_ready, 1'b1);
    chk("rst_async_busy5", rs1_busy, 1'b0);
    chk("rst_async_RegWrite", RegWrite, 1'b0);
    chk("rst_async_stall", wb_stall, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Priority: WB wins, queued entry written on the next idle-WB cycle
    set_idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h55;
    step();
    issue_valid = 1'b0; mc_valid = 1'b0; rs1Addr = 5'd7;
    #1;
    chk("prio_wb_addr", WriteAddr, 5'd3);
    chk("prio_wb_data", WriteData, 32'hAA);
    chk("prio_busy7", rs1_busy, 1'b1);
    step();
    wb_we = 1'b0;
    #1;
    chk("prio_mc_we", RegWrite, 1'b1);
    chk("prio_mc_addr", WriteAddr, 5'd7);
    chk("prio_mc_data", WriteData, 32'h55);
    step();
    chk("prio_busy7_clr", rs1_busy, 1'b0);

    // Starvation: WB held on x1 with one entry queued
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hB1;
    mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h77;
    step();
    mc_valid = 1'b0;
    for (int i = 1; i <= SL + 2; i++) begin
      #1;
      chk("starve_stall", wb_stall, i == SL + 1);
      chk("starve_addr", WriteAddr, (i == SL + 1) ? 5'd12 : 5'd1);
      step();
    end

    // Full FIFO, then in-order drain while mc_valid stays asserted
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'hF0;
    mc_valid = 1'b1; mc_addr = 5'd20; mc_data = 32'd1;
    step();
    mc_addr = 5'd21; mc_data = 32'd2;
    step();
    mc_addr = 5'd22; mc_data = 32'd3; wb_we = 1'b0;
    #1;
    chk("full_ready", mc_ready, 1'b0);
    chk("full_head", WriteAddr, 5'd20);
    step();
    #1;
    chk("full_ready_after_pop", mc_ready, 1'b1);
    chk("drain_2_addr", WriteAddr, 5'd21);
    chk("drain_2_data", WriteData, 32'd2);
    step();
    mc_valid = 1'b0;
    #1;
    chk("drain_3_addr", WriteAddr, 5'd22);
    chk("drain_3_data", WriteData, 32'd3);
    step();
    #1;
    chk("drained", RegWrite, 1'b0);
    step();

    // x0 handling on every path
    wb_we = 1'b1; wb_addr = 5'd1; mc_valid = 1'b1; mc_addr = 5'd13; mc_data = 32'h99;
    step();
    mc_valid = 1'b0; wb_addr = 5'd0;
    #1;
    chk("x0_pops", RegWrite, 1'b1);
    chk("x0_pop_addr", WriteAddr, 5'd13);
    step();
    #1;
    chk("x0_dropped", RegWrite, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd0; rs1Addr = 5'd0;
    step();
    issue_valid = 1'b0;
    #1;
    chk("x0_issue", rs1_busy, 1'b0);
    wb_we = 1'b0; mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hDEAD;
    #1;
    chk("x0_mc_ready", mc_ready, 1'b1);
    step();
    mc_valid = 1'b0;
    #1;
    chk("x0_mc_not_pushed", RegWrite, 1'b0);
    step();

    // Scoreboard rise and fall around a multi-cycle write
    rs2Addr = 5'd9; issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    chk("sb_before", rs2_busy, 1'b0);
    step();
    issue_valid = 1'b0;
    #1;
    chk("sb_rise", rs2_busy, 1'b1);
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h1234;
    step();
    mc_valid = 1'b0;
    #1;
    chk("sb_port_data", WriteData, 32'h1234);
    chk("sb_busy_in_pop", rs2_busy, 1'b1);
    step();
    chk("sb_fall", rs2_busy, 1'b0);

    // Random traffic with one mid-run asynchronous reset
    for (int i = 0; i < 400; i++) begin
      wb_we       = ($urandom_range(0, 9) < 7);
      wb_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data     = $urandom;
      mc_valid    = ($urandom_range(0, 1) == 1);
      mc_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mc_data     = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rs1Addr     = 5'($urandom_range(0, 31));
      rs2Addr     = 5'($urandom_range(0, 31));
      if (i == 200) begin
        wb_we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_ready", mc_ready, 1'b1);
        chk("rnd_rst_RegWrite", RegWrite, 1'b0);
        chk("rnd_rst_rs1", rs1_busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
